// File: rtl/request_capture.sv
// request_capture: synchronises raw request lines, latches rising edges as sticky pending bits, tracks overflow and event count
module request_capture (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] mask,
  input  logic       ack,
  input  logic [1:0] ack_code,
  input  logic       ovf_clr,
  output logic [3:0] pending,
  output logic       any_pending,
  output logic [3:0] overflow,
  output logic       ack_err,
  output logic [7:0] event_count
);
  logic [3:0] s1, s2, s3, rise, ack_hit, pending_n, ovf_set;
  logic [2:0] n;
  logic [8:0] sum;
  always_comb begin
    rise      = s2 & ~s3 & ~mask;
    ack_hit   = ack ? (4'b0001 << ack_code) : 4'b0000;
    pending_n = rise | (pending & ~ack_hit);
    ovf_set   = rise & pending & ~ack_hit;
    n         = {2'b0, rise[0]} + {2'b0, rise[1]} + {2'b0, rise[2]} + {2'b0, rise[3]};
    sum       = {1'b0, event_count} + {6'b0, n};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1          <= '0;
      s2          <= '0;
      s3          <= '0;
      pending     <= '0;
      any_pending <= 1'b0;
      overflow    <= '0;
      ack_err     <= 1'b0;
      event_count <= '0;
    end else begin
      s1          <= req;
      s2          <= s1;
      s3          <= s2;
      pending     <= pending_n;
      any_pending <= |pending_n;
      overflow    <= ovf_clr ? ovf_set : (overflow | ovf_set);
      ack_err     <= ack & ~pending[ack_code] & ~rise[ack_code];
      event_count <= sum[8] ? 8'hff : sum[7:0];
    end
  end
endmodule
